// File: rtl/gcode_cmd_sequencer_if.sv
// rtl/gcode_cmd_sequencer_if.sv - program RAM read port and controller issue port of the G-code sequencer
interface gcode_cmd_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic [3:0]        cmd;
  logic [13:0]       x_value_out;
  logic [13:0]       y_value_out;
  logic              memory_ready;
  logic              controller_ready;

  modport master (
    output mem_addr, mem_rd_en, cmd, x_value_out, y_value_out, memory_ready,
    input  mem_rdata, controller_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, cmd, x_value_out, y_value_out, memory_ready,
    output mem_rdata, controller_ready
  );
endinterface

// File: rtl/gcode_cmd_sequencer.sv
// rtl/gcode_cmd_sequencer.sv - steps a stored G-code program into the SCARA controller interface
// Optional SEQ_LOOP_EN: an issued M2 restarts the program at address 0 instead of stopping.
module gcode_cmd_sequencer #(
  parameter int ADDR_W        = 10,
  parameter int PROG_DEPTH    = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  block,
  gcode_cmd_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      cmd_count
);
`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int                SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [3:0]        OP_M2       = 4'd6;
  localparam logic [3:0]        OP_MAX      = 4'd8;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(PROG_DEPTH - 1);
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, DECODE, ISSUE, SETTLE, DONE} state_t;

  state_t          state, state_nx;
  logic [SC_W-1:0] settle_cnt;
  logic            issue_fire;
  logic            restart;

  always_comb begin
    state_nx         = state;
    issue_fire       = 1'b0;
    restart          = 1'b0;
    bus.mem_rd_en    = 1'b0;
    bus.memory_ready = 1'b0;
    busy             = (state != IDLE) && (state != DONE) && !block;
    done             = (state == DONE);
    if (block) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx = FETCH;
            restart  = 1'b1;
          end
        end
        FETCH: begin
          bus.mem_rd_en = 1'b1;
          state_nx      = WAIT_RD;
        end
        WAIT_RD: state_nx = DECODE;
        DECODE:  state_nx = (bus.cmd > OP_MAX) ? DONE : ISSUE;
        ISSUE: begin
          if (bus.controller_ready && !pause) begin
            bus.memory_ready = 1'b1;
            issue_fire       = 1'b1;
            if (bus.cmd == OP_M2) state_nx = LOOP_EN ? FETCH : DONE;
            else                  state_nx = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST)
            state_nx = (bus.mem_addr == LAST_ADDR) ? DONE : FETCH;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath updates are suppressed while block is high so count and err hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.mem_addr    <= '0;
      bus.cmd         <= '0;
      bus.x_value_out <= '0;
      bus.y_value_out <= '0;
      settle_cnt      <= '0;
      cmd_count       <= '0;
      err             <= 1'b0;
    end else begin
      state <= state_nx;
      if (restart) begin
        bus.mem_addr <= '0;
        cmd_count    <= '0;
        err          <= 1'b0;
      end
      if (!block) begin
        case (state)
          WAIT_RD: {bus.cmd, bus.x_value_out, bus.y_value_out} <= bus.mem_rdata;
          DECODE:  if (bus.cmd > OP_MAX) err <= 1'b1;
          ISSUE: begin
            if (issue_fire) begin
              if (!(&cmd_count)) cmd_count <= cmd_count + 1'b1;
              settle_cnt <= '0;
              if (LOOP_EN && bus.cmd == OP_M2) bus.mem_addr <= '0;
            end
          end
          SETTLE: begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
              if (bus.mem_addr == LAST_ADDR) err <= 1'b1;
              else                           bus.mem_addr <= bus.mem_addr + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gcode_cmd_sequencer.sv
// tb/tb_gcode_cmd_sequencer.sv - table-driven and directed-sequence checks for gcode_cmd_sequencer
module tb_gcode_cmd_sequencer;
  localparam int ADDR_W = 10, PROG_DEPTH = 4, SETTLE_CYCLES = 4, CNT_W = 2;
`ifdef SEQ_LOOP_EN
  localparam bit SKIP_M2 = 1'b1;
`else
  localparam bit SKIP_M2 = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, pause = 1'b0, block = 1'b0;
  logic busy, done, err;
  logic [CNT_W-1:0] cmd_count;

  gcode_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  gcode_cmd_sequencer #(.ADDR_W(ADDR_W), .PROG_DEPTH(PROG_DEPTH),
                        .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .block(block),
    .bus(bus), .busy(busy), .done(done), .err(err), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [PROG_DEPTH];
  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rdata <= prog[bus.mem_addr[1:0]];

  int          cyc = 0, start_cyc = 0;
  logic [31:0] pword[$];
  int          pcyc[$];
  bit          addr_over = 1'b0, rd_seen = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.memory_ready) begin
      pword.push_back({bus.cmd, bus.x_value_out, bus.y_value_out});
      pcyc.push_back(cyc);
    end
    if (start) start_cyc = cyc;
    if (bus.mem_rd_en) rd_seen = 1'b1;
    if (bus.mem_addr > ADDR_W'(PROG_DEPTH - 1)) addr_over = 1'b1;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] w(input int c, input int x, input int y);
    return {4'(c), 14'(x), 14'(y)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic clear_mon();
    pword.delete(); pcyc.delete(); addr_over = 1'b0; rd_seen = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    while (!done && t < budget) begin step(1); t++; end
    chk(name, done, 1'b1);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int t = 0;
    while (pword.size() < n && t < budget) begin step(1); t++; end
    chk(name, 32'(pword.size() >= n), 32'd1);
  endtask

  task automatic stop_run();
    block = 1'b1; step(1); block = 1'b0; step(1);
  endtask

  task automatic load(input logic [31:0] a, b, c, d);
    prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d;
  endtask

  typedef struct {
    logic [31:0] p [4];
    int          pulses;
    int          count;
    bit          err;
    bit          m2;
  } vec_t;
  vec_t vec [6];

  task automatic set_vec(input int i, input logic [31:0] a, b, c, d,
                         input int pulses, input int count, input bit e, input bit m2);
    vec[i].p[0] = a; vec[i].p[1] = b; vec[i].p[2] = c; vec[i].p[3] = d;
    vec[i].pulses = pulses; vec[i].count = count; vec[i].err = e; vec[i].m2 = m2;
  endtask

  initial begin
    set_vec(0, w(4,0,0), w(1,100,200), w(6,0,0), w(0,0,0), 3, 3, 1'b0, 1'b1);
    set_vec(1, w(4,0,0), w(12,5,5), w(6,0,0), w(0,0,0), 1, 1, 1'b1, 1'b0);
    set_vec(2, w(1,1,2), w(6,0,0), w(0,0,0), w(0,0,0), 2, 2, 1'b0, 1'b1);
    set_vec(3, w(1,1,1), w(1,2,2), w(0,3,3), w(3,0,0), 4, 3, 1'b1, 1'b0);
    set_vec(4, w(6,7,7), w(1,0,0), w(0,0,0), w(0,0,0), 1, 1, 1'b0, 1'b1);
    set_vec(5, w(8,16383,16383), w(9,0,0), w(0,0,0), w(0,0,0), 1, 1, 1'b1, 1'b0);
    bus.controller_ready = 1'b0;
    load(0, 0, 0, 0);

    step(2);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_outs", {bus.mem_rd_en, bus.memory_ready, busy, done, err}, 0);
    chk("rst_cmd", {bus.cmd, bus.x_value_out, bus.y_value_out}, 0);
    chk("rst_count", 32'(cmd_count), 0);
    reset_n = 1'b1;
    step(1);

    for (int i = 0; i < 6; i++) begin
      if (SKIP_M2 && vec[i].m2) continue;
      load(vec[i].p[0], vec[i].p[1], vec[i].p[2], vec[i].p[3]);
      clear_mon();
      bus.controller_ready = 1'b1;
      do_start();
      wait_done(300, $sformatf("v%0d_done", i));
      chk($sformatf("v%0d_pulses", i), 32'(pword.size()), 32'(vec[i].pulses));
      chk($sformatf("v%0d_count", i), 32'(cmd_count), 32'(vec[i].count));
      chk($sformatf("v%0d_err", i), err, vec[i].err);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      chk($sformatf("v%0d_addr_range", i), addr_over, 1'b0);
      for (int p = 0; p < pword.size() && p < 4; p++)
        chk($sformatf("v%0d_word%0d", i, p), pword[p], vec[i].p[p]);
      if (i == 0 && pcyc.size() >= 2) begin
        chk("start_latency", 32'(pcyc[0] - start_cyc), 32'd4);
        chk("issue_gap", 32'(pcyc[1] - pcyc[0]), 32'(SETTLE_CYCLES + 4));
      end
    end

    // controller_ready low across the second ISSUE
    load(w(4,0,0), w(1,100,200), w(6,0,0), w(0,0,0));
    clear_mon();
    bus.controller_ready = 1'b1;
    do_start();
    wait_pulses(1, 50, "stall_first");
    bus.controller_ready = 1'b0;
    step(30);
    chk("stall_no_pulse", 32'(pword.size()), 32'd1);
    chk("stall_busy", busy, 1'b1);
    chk("stall_cmd", {bus.cmd, bus.x_value_out, bus.y_value_out}, w(1,100,200));
    bus.controller_ready = 1'b1;
    step(1);
    chk("stall_one_pulse", 32'(pword.size()), 32'd2);
    if (pword.size() >= 2) chk("stall_word", pword[1], w(1,100,200));
    chk("stall_hold", {bus.cmd, bus.x_value_out, bus.y_value_out}, w(1,100,200));
    stop_run();

    // pause delays issue only
    clear_mon();
    pause = 1'b1;
    do_start();
    step(12);
    chk("pause_no_pulse", 32'(pword.size()), 32'd0);
    chk("pause_fetched", rd_seen, 1'b1);
    chk("pause_busy", busy, 1'b1);
    pause = 1'b0;
    step(1);
    chk("pause_release", 32'(pword.size()), 32'd1);
    stop_run();

    // block during SETTLE after command 2, start in the same cycle is ignored
    load(w(4,0,0), w(1,100,200), w(12,0,0), w(0,0,0));
    clear_mon();
    do_start();
    wait_pulses(2, 60, "block_pulses");
    block = 1'b1; start = 1'b1;
    step(1);
    chk("block_busy", busy, 1'b0);
    chk("block_outs", {bus.memory_ready, bus.mem_rd_en, done}, 0);
    chk("block_count", 32'(cmd_count), 32'd2);
    chk("block_err", err, 1'b0);
    block = 1'b0; start = 1'b0;
    step(3);
    chk("block_idle", {busy, done, bus.mem_rd_en}, 0);
    clear_mon();
    do_start();
    wait_done(100, "rerun_done");
    chk("rerun_pulses", 32'(pword.size()), 32'd2);
    if (pword.size() >= 1) chk("rerun_addr0", pword[0], w(4,0,0));
    chk("rerun_err", err, 1'b1);

`ifdef SEQ_LOOP_EN
    load(w(1,1,2), w(6,0,0), w(0,0,0), w(0,0,0));
    clear_mon();
    bus.controller_ready = 1'b1;
    do_start();
    wait_pulses(5, 200, "loop_pulses");
    for (int k = 0; k < 5 && k < pword.size(); k++)
      chk($sformatf("loop_word%0d", k), pword[k], (k % 2 == 0) ? w(1,1,2) : w(6,0,0));
    chk("loop_done", done, 1'b0);
    chk("loop_count_sat", 32'(cmd_count), 32'd3);
    stop_run();
`endif

    // reset mid-transfer while waiting at ISSUE
    load(w(4,9,9), w(6,0,0), w(0,0,0), w(0,0,0));
    bus.controller_ready = 1'b0;
    do_start();
    step(6);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_outs", {bus.memory_ready, bus.mem_rd_en, busy, done, err}, 0);
    chk("mid_rst_cmd", {bus.cmd, bus.x_value_out, bus.y_value_out}, 0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 0);
    step(1);
    reset_n = 1'b1;
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
